// File: rtl/home_rr_event_arbiter.sv
// ============================================================================
// home_rr_event_arbiter
//
// Purpose:
//   Latches requests from N_DIG digital sensors plus a cold and a hot
//   temperature channel into a pending register. Pending channels are served
//   one at a time with round-robin arbitration. A granted channel holds its
//   one-hot actuator enable for HOLD_CYC cycles, or less if SVC_ACK ends the
//   service early. The display shows the served channel index + 1.
//
// Optional feature (macro HOME_URGENT_EN):
//   When defined, channel 0 (front door) is urgent. In IDLE a pending
//   channel 0 is granted ahead of the rotation, and the rotation pointer is
//   left unchanged. An active service is never preempted.
//
// Ports:
//   Clk      in   1       clock, rising edge
//   Rst      in   1       synchronous active-high reset
//   SENS     in   N_DIG   digital sensor levels, bit k = channel k
//   ST       in   TEMP_W  unsigned temperature reading
//   SVC_ACK  in   1       early service-complete from the actuator side
//   act      out  N_CH    one-hot actuator enables (all zero when idle)
//   display  out  DISP_W  served channel index + 1, 0 when idle
//   busy     out  1       high while serving a channel
//   pend     out  N_CH    pending-request register
// ============================================================================
module home_rr_event_arbiter #(
    parameter  int N_DIG    = 4,
    parameter  int TEMP_W   = 7,
    parameter  int TEMP_LO  = 50,
    parameter  int TEMP_HI  = 70,
    parameter  int HOLD_CYC = 4,
    localparam int N_CH     = N_DIG + 2,
    localparam int DISP_W   = $clog2(N_CH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [N_DIG-1:0]  SENS,
    input  logic [TEMP_W-1:0] ST,
    input  logic              SVC_ACK,
    output logic [N_CH-1:0]   act,
    output logic [DISP_W-1:0] display,
    output logic              busy,
    output logic [N_CH-1:0]   pend
);

    localparam int PTR_W = $clog2(N_CH);
    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [TEMP_W-1:0] LO_TH = TEMP_W'(TEMP_LO);
    localparam logic [TEMP_W-1:0] HI_TH = TEMP_W'(TEMP_HI);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic             cold;
    logic             hot;
    logic [N_CH-1:0]  req;
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [N_CH-1:0]  clr;

    // Thresholds are strict: a reading equal to either threshold is quiet.
    assign cold = (ST < LO_TH);
    assign hot  = (ST > HI_TH);
    assign req  = {hot, cold, SENS};

    // Only the registered pend vector is arbitrated, so a request always
    // takes one edge to latch before it can be granted.
    assign grant_valid = (state == IDLE) && (|pend);

    // Round-robin search starting at ptr and wrapping; the first pending
    // channel found wins. The pointer moves to the channel after the winner.
    always_comb begin
        logic             found;
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        grant_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            cand_idx = PTR_W'(cand);
            if (!found && pend[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        next_ptr = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + PTR_W'(1);
`ifdef HOME_URGENT_EN
        // The front door jumps the queue without disturbing the rotation.
        if (pend[0]) begin
            grant_idx = '0;
            next_ptr  = ptr;
        end
`endif
    end

    // One-hot clear of the channel granted at this edge; clear beats a
    // same-edge set, and a still-active source re-latches on the next edge.
    assign clr = grant_valid ? (N_CH'(1) << grant_idx) : '0;

    // Single state machine with all outputs registered. A grant sets the
    // hold counter to HOLD_CYC-1 so act stays high exactly HOLD_CYC cycles;
    // SVC_ACK ends service early. Leaving SERVE always passes through IDLE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            act     <= '0;
            display <= '0;
            busy    <= 1'b0;
            pend    <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            pend <= (pend | req) & ~clr;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state   <= SERVE;
                        act     <= N_CH'(1) << grant_idx;
                        display <= DISP_W'(grant_idx) + DISP_W'(1);
                        busy    <= 1'b1;
                        cnt     <= CNT_W'(HOLD_CYC - 1);
                        ptr     <= next_ptr;
                    end
                end
                SERVE: begin
                    if ((cnt == '0) || SVC_ACK) begin
                        state   <= IDLE;
                        act     <= '0;
                        display <= '0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    act     <= '0;
                    display <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_home_rr_event_arbiter.sv
// ============================================================================
// tb_home_rr_event_arbiter
//
// Directed testbench for home_rr_event_arbiter with default parameters
// (N_DIG=4, TEMP_LO=50, TEMP_HI=70, HOLD_CYC=4). Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// ============================================================================
module tb_home_rr_event_arbiter;

    logic       Clk;
    logic       Rst;
    logic [3:0] SENS;
    logic [6:0] ST;
    logic       SVC_ACK;
    logic [5:0] act;
    logic [2:0] display;
    logic       busy;
    logic [5:0] pend;

    int checks;
    int failures;

    home_rr_event_arbiter dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .SENS    (SENS),
        .ST      (ST),
        .SVC_ACK (SVC_ACK),
        .act     (act),
        .display (display),
        .busy    (busy),
        .pend    (pend)
    );

    // 10 time-unit clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Two reset cycles with quiet inputs, then release.
    task automatic do_reset();
        Rst     = 1'b1;
        SENS    = 4'b0000;
        ST      = 7'd60;
        SVC_ACK = 1'b0;
        step();
        step();
        Rst = 1'b0;
    endtask

    // Reset with every source active; first grant afterwards is channel 0.
    task automatic test_reset();
        Rst     = 1'b1;
        SENS    = 4'b1111;
        ST      = 7'd0;
        SVC_ACK = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({act, display, busy, pend} !== 16'h0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cyc=%0d act=%b display=%0d busy=%b pend=%b expected all zero",
                         c, act, display, busy, pend);
            end
        end
        Rst = 1'b0;
        step();
        checks++;
        if (act !== 6'b0 || pend !== 6'b011111) begin
            failures++;
            $display("[TB] FAIL reset_latch act=%b pend=%b expected act=000000 pend=011111", act, pend);
        end
        step();
        checks++;
        if (act !== 6'b000001 || display !== 3'd1 || busy !== 1'b1 || pend !== 6'b011110) begin
            failures++;
            $display("[TB] FAIL reset_first_grant act=%b display=%0d busy=%b pend=%b expected 000001/1/1/011110",
                     act, display, busy, pend);
        end
    endtask

    // One-cycle pulse on SENS[1]: latched, granted for 4 cycles, then idle.
    task automatic test_single_pulse();
        do_reset();
        SENS = 4'b0010;
        step();
        SENS = 4'b0000;
        checks++;
        if (pend !== 6'b000010 || act !== 6'b0) begin
            failures++;
            $display("[TB] FAIL pulse_latch pend=%b act=%b expected pend=000010 act=000000", pend, act);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (act !== 6'b000010 || display !== 3'd2 || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL pulse_serve cyc=%0d act=%b display=%0d busy=%b expected 000010/2/1",
                         c, act, display, busy);
            end
        end
        step();
        checks++;
        if (act !== 6'b0 || display !== 3'd0 || busy !== 1'b0 || pend !== 6'b0) begin
            failures++;
            $display("[TB] FAIL pulse_release act=%b display=%0d busy=%b pend=%b expected all zero",
                     act, display, busy, pend);
        end
    endtask

    // All digital sensors held: grants rotate 0,1,2,3,0,1 with 4 active
    // cycles and 1 idle cycle each; temperature channels stay silent.
    task automatic test_round_robin();
        logic [5:0] exp_act;
        do_reset();
        SENS = 4'b1111;
        ST   = 7'd60;
        step();
        for (int g = 0; g < 6; g++) begin
            exp_act = 6'b000001 << (g % 4);
            for (int c = 0; c < 4; c++) begin
                step();
                checks++;
                if (act !== exp_act || display !== 3'((g % 4) + 1)) begin
                    failures++;
                    $display("[TB] FAIL rr_grant g=%0d cyc=%0d act=%b display=%0d expected act=%b display=%0d",
                             g, c, act, display, exp_act, (g % 4) + 1);
                end
            end
            step();
            checks++;
            if (act !== 6'b0 || display !== 3'd0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rr_idle_gap g=%0d act=%b display=%0d busy=%b expected idle",
                         g, act, display, busy);
            end
        end
        SENS = 4'b0000;
    endtask

    // Cold (ST<50) and hot (ST>70) channels; equal-to-threshold is quiet.
    task automatic test_temperature();
        logic [6:0] temps  [2];
        logic [5:0] acts   [2];
        logic [6:0] quiet  [2];
        temps[0] = 7'd40; acts[0] = 6'b010000;
        temps[1] = 7'd80; acts[1] = 6'b100000;
        quiet[0] = 7'd50; quiet[1] = 7'd70;
        do_reset();
        for (int t = 0; t < 2; t++) begin
            ST = temps[t];
            step();
            ST = 7'd60;
            step();
            checks++;
            if (act !== acts[t] || display !== 3'(5 + t)) begin
                failures++;
                $display("[TB] FAIL temp_grant ST=%0d act=%b display=%0d expected act=%b display=%0d",
                         temps[t], act, display, acts[t], 5 + t);
            end
            for (int c = 0; c < 4; c++) step();
            checks++;
            if (act !== 6'b0 || pend !== 6'b0) begin
                failures++;
                $display("[TB] FAIL temp_release ST=%0d act=%b pend=%b expected zero", temps[t], act, pend);
            end
        end
        for (int q = 0; q < 2; q++) begin
            ST = quiet[q];
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if (act !== 6'b0 || pend !== 6'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL temp_threshold ST=%0d act=%b pend=%b busy=%b expected quiet",
                             quiet[q], act, pend, busy);
                end
            end
        end
        ST = 7'd60;
    endtask

    // SVC_ACK in the second SERVE cycle ends the grant after 2 cycles; the
    // next pending channel follows after one idle cycle. SVC_ACK in IDLE
    // has no effect.
    task automatic test_svc_ack();
        do_reset();
        SVC_ACK = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || act !== 6'b0) begin
            failures++;
            $display("[TB] FAIL ack_in_idle busy=%b act=%b expected idle", busy, act);
        end
        SVC_ACK = 1'b0;
        SENS = 4'b0110;
        step();
        SENS = 4'b0000;
        step();
        checks++;
        if (act !== 6'b000010 || pend !== 6'b000100) begin
            failures++;
            $display("[TB] FAIL ack_first_grant act=%b pend=%b expected 000010/000100", act, pend);
        end
        step();
        checks++;
        if (act !== 6'b000010) begin
            failures++;
            $display("[TB] FAIL ack_second_cycle act=%b expected 000010", act);
        end
        SVC_ACK = 1'b1;
        step();
        SVC_ACK = 1'b0;
        checks++;
        if (act !== 6'b0 || display !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ack_early_end act=%b display=%0d busy=%b expected idle", act, display, busy);
        end
        step();
        checks++;
        if (act !== 6'b000100 || display !== 3'd3) begin
            failures++;
            $display("[TB] FAIL ack_next_grant act=%b display=%0d expected 000100/3", act, display);
        end
    endtask

    // ptr=1 with channels 0 and 2 pending: order depends on HOME_URGENT_EN.
    task automatic test_urgent();
        logic [5:0] first_act;
        logic [5:0] second_act;
`ifdef HOME_URGENT_EN
        first_act  = 6'b000001;
        second_act = 6'b000100;
`else
        first_act  = 6'b000100;
        second_act = 6'b000001;
`endif
        do_reset();
        SENS = 4'b0001;
        step();
        SENS = 4'b0000;
        step();
        SENS = 4'b0101;
        step();
        SENS = 4'b0000;
        step();
        step();
        step();
        checks++;
        if (act !== 6'b0 || pend !== 6'b000101) begin
            failures++;
            $display("[TB] FAIL urgent_setup act=%b pend=%b expected 000000/000101", act, pend);
        end
        step();
        checks++;
        if (act !== first_act) begin
            failures++;
            $display("[TB] FAIL urgent_first act=%b expected %b", act, first_act);
        end
        for (int c = 0; c < 4; c++) step();
        step();
        checks++;
        if (act !== second_act) begin
            failures++;
            $display("[TB] FAIL urgent_second act=%b expected %b", act, second_act);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_pulse();
        test_round_robin();
        test_temperature();
        test_svc_ack();
        test_urgent();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
